// File: rtl/bcd_a_binario_serial.sv
// Serial packed-BCD to binary converter, one digit per clock, MSD first (acc = acc*10 + digit).
// Define BCD_CHECK_EN to flag digits above 9 and force bin_out to all ones on error.
module bcd_a_binario_serial #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err_out
);

  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_t;

  state_t               state_q, state_d;
  logic [4*DIGITS-1:0]  shift_q, shift_d;
  logic [BIN_W-1:0]     acc_q, acc_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 err_q, err_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic                 err_out_q, err_out_d;

  logic [3:0]           digit;
  logic [BIN_W+3:0]     acc_ext;
  logic [BIN_W+3:0]     horner;
  logic [BIN_W-1:0]     acc_next;
  logic                 err_next;
  logic [BIN_W-1:0]     bin_final;

  assign digit    = shift_q[4*DIGITS-1 -: 4];
  assign acc_ext  = {4'b0000, acc_q};
  assign horner   = (acc_ext << 3) + (acc_ext << 1) + {{BIN_W{1'b0}}, digit};
  assign acc_next = horner[BIN_W-1:0];

`ifdef BCD_CHECK_EN
  assign err_next  = err_q | (digit > 4'd9);
  assign bin_final = err_next ? {BIN_W{1'b1}} : acc_next;
`else
  // Without the check, nibbles 10..15 enter the Horner step at face value.
  assign err_next  = 1'b0;
  assign bin_final = acc_next;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    count_d   = count_q;
    err_d     = err_q;
    bin_d     = bin_q;
    err_out_d = err_out_q;
    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          shift_d = bcd_in;
          acc_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
          state_d = StConvert;
        end
      end
      StConvert: begin
        acc_d   = acc_next;
        shift_d = shift_q << 4;
        count_d = count_q + CntW'(1);
        err_d   = err_next;
        if (count_q == LastCnt) begin
          bin_d     = bin_final;
          err_out_d = err_next;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (ready_out) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      bin_q     <= '0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      err_q     <= err_d;
      bin_q     <= bin_d;
      err_out_q <= err_out_d;
    end
  end

  assign ready_in  = (state_q == StIdle);
  assign valid_out = (state_q == StDone);
  assign bin_out   = bin_q;
  assign err_out   = err_out_q;

endmodule

// File: tb/tb_bcd_a_binario_serial.sv
// Scoreboard bench for bcd_a_binario_serial: stimulus pushes expected results, a monitor pops on
// each output handshake. Directed vectors with hand-computed values.
module tb_bcd_a_binario_serial;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned BIN_W  = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_in;
  logic              ready_in;
  logic [15:0]       bcd_in;
  logic              valid_out;
  logic              ready_out;
  logic [BIN_W-1:0]  bin_out;
  logic              err_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic             err;
  } exp_t;
  exp_t sb_q[$];

  bcd_a_binario_serial #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .bcd_in    (bcd_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .bin_out   (bin_out),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: handshake completes at the next rising edge whenever both are high here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_out && ready_out) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got bin %0h err %0b expected none", bin_out, err_out);
        end else begin
          e = sb_q.pop_front();
          check("bin_out", 32'(bin_out), 32'(e.bin));
          check("err_out", 32'(err_out), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [BIN_W-1:0] b, input logic e);
    exp_t x;
    x.bin = b;
    x.err = e;
    sb_q.push_back(x);
  endtask

  // Present a word and return #1 after its accept edge.
  task automatic accept(input logic [15:0] w);
    int n = 0;
    @(negedge clk);
    while (!ready_in && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready_in) check("ready_in_wait", 32'(ready_in), 32'd1);
    valid_in = 1'b1;
    bcd_in   = w;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    bcd_in   = 16'hFFFF;
  endtask

  // Called #1 after the accept edge: checks latency, stability while stalled, release.
  // With noise set, valid_in/bcd_in toggle during CONVERT. With chain set, the next word is
  // presented in the same cycle ready_out releases the result.
  task automatic finish_result(input int hold, input logic [BIN_W-1:0] exp_bin, input bit noise,
                               input bit chain, input logic [15:0] nxt);
    for (int k = 1; k <= DIGITS; k++) begin
      @(posedge clk);
      #1;
      if (noise) begin
        valid_in = (k < DIGITS) ? k[0] : 1'b0;
        bcd_in   = 16'h7777;
      end
      @(negedge clk);
      if (k == 1) check("ready_in_busy", 32'(ready_in), 32'd0);
      if (k == DIGITS - 1) check("valid_early", 32'(valid_out), 32'd0);
      if (k == DIGITS) check("valid_latency", 32'(valid_out), 32'd1);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("valid_hold", 32'(valid_out), 32'd1);
      check("bin_hold", 32'(bin_out), 32'(exp_bin));
    end
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    if (chain) begin
      valid_in = 1'b1;
      bcd_in   = nxt;
    end
    @(posedge clk);
    #1;
    ready_out = 1'b0;
    @(negedge clk);
    check("valid_release", 32'(valid_out), 32'd0);
    check("ready_in_back", 32'(ready_in), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    bcd_in    = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_in", 32'(ready_in), 32'd1);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_bin_out", 32'(bin_out), 32'd0);
    check("rst_err_out", 32'(err_out), 32'd0);
    rst_n = 1'b1;

    push(14'd0, 1'b0);
    accept(16'h0000);
    finish_result(0, 14'd0, 1'b0, 1'b0, 16'h0);

    push(14'h270F, 1'b0);
    accept(16'h9999);
    finish_result(0, 14'h270F, 1'b0, 1'b0, 16'h0);

    push(14'h04D2, 1'b0);
    accept(16'h1234);
    finish_result(3, 14'h04D2, 1'b0, 1'b0, 16'h0);

`ifdef BCD_CHECK_EN
    push(14'h3FFF, 1'b1);
    accept(16'h12A4);
    finish_result(1, 14'h3FFF, 1'b0, 1'b0, 16'h0);
`else
    push(14'd1304, 1'b0);
    accept(16'h12A4);
    finish_result(1, 14'd1304, 1'b0, 1'b0, 16'h0);
`endif

    // 7777 offered during CONVERT and again in DONE; accepted only once ready_in returns.
    push(14'd42, 1'b0);
    push(14'd7777, 1'b0);
    accept(16'h0042);
    finish_result(0, 14'd42, 1'b1, 1'b1, 16'h7777);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    bcd_in   = 16'hFFFF;
    finish_result(0, 14'd7777, 1'b0, 1'b0, 16'h0);

    // Reset two cycles into a conversion: result must never appear.
    accept(16'h5555);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_valid_out", 32'(valid_out), 32'd0);
    check("abort_ready_in", 32'(ready_in), 32'd1);
    check("abort_bin_out", 32'(bin_out), 32'd0);
    check("abort_err_out", 32'(err_out), 32'd0);
    ready_out = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_valid", 32'(valid_out), 32'd0);
    ready_out = 1'b0;

    push(14'd7, 1'b0);
    accept(16'h0007);
    finish_result(0, 14'd7, 1'b0, 1'b0, 16'h0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
